led_scan_sequencer: RTL
=======================

Name: led_scan_sequencer

Overview:
Parametrised scan/PWM timing generator for the LED cube panel drivers; supersedes the fixed 19-bit counter plus control ROM sequencing. It produces the per-slot load/shift/sclk/latch strobes, PWM time, row address and row selects for any row count, PWM depth and shift length. It adds anti-ghosting row blanking, a frame-synchronous double-buffer swap handshake, on-request (not per-frame) brightness loading, and a clean run/stop enable.

Parameters:
NUM_ROWS, 16, number of multiplexed rows (>=2)
ROW_ADDR_W, 4, row address width, = clog2(NUM_ROWS)
PWM_BITS, 8, PWM resolution; 2**PWM_BITS slots per row
SHIFT_BITS, 32, serial clock pulses per slot (>=1)
BLANK_CYCLES, 4, dead cycles between rows (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run request; sampled in IDLE and at frame boundary
swap_req  in  1  front/back buffer swap request, hold until swap_ack
bright_req  in  1  brightness-load request, hold until bright_ack
serial_clk  out  1  driver shift clock
shift  out  1  panel drivers advance shift data
load_led_vals  out  1  panel drivers capture LED PWM data
load_brightness  out  1  panel drivers capture brightness data
latch_enable  out  1  driver latch strobe
output_enable_n  out  1  driver output enable, active low
pwm_time  out  PWM_BITS  current PWM slot
active_row_addr  out  ROW_ADDR_W  current row
row_select_n  out  NUM_ROWS  one-cold row drive
display_buf  out  1  buffer currently displayed
frame_start  out  1  pulse at first cycle of each frame
swap_ack  out  1  one-cycle swap acknowledge
bright_ack  out  1  one-cycle brightness acknowledge

Behaviour:
- Reset (async, any time incl. mid-frame): state IDLE, all counters 0, strobes/serial_clk/acks/frame_start 0, output_enable_n 1, row_select_n all 1, pwm_time 0, active_row_addr 0, display_buf 0. Pending requests are not remembered.
- All outputs are functions of registered state only; no input-to-output combinational path.
- States: IDLE, SCAN, BLANK, BRIGHT.
- STEP_LEN = 2*SHIFT_BITS+3. Within a slot, step counter s = 0..STEP_LEN-1:
  s=0: load_led_vals=1 (load_brightness=1 in BRIGHT); s odd in 1..2*SHIFT_BITS: shift=1, serial_clk=0; s even in 2..2*SHIFT_BITS: serial_clk=1; s=2*SHIFT_BITS+1: latch_enable=1; s=STEP_LEN-1: idle.
- IDLE: oe_n=1, rows off. enable=1 -> SCAN, row 0, slot 0, s=0 next cycle.
- SCAN: oe_n=0; row_select_n[active_row_addr]=0, all others 1; pwm_time=slot. frame_start=1 when row=0, slot=0, s=0. At s=STEP_LEN-1: slot<2**PWM_BITS-1 -> slot+1, s=0; else -> BLANK, blank counter 0.
- BLANK: oe_n=1, row_select_n all 1, strobes 0, counter 0..BLANK_CYCLES-1. At last cycle: row<NUM_ROWS-1 -> row+1, slot 0, SCAN; else frame boundary.
- Frame boundary (last BLANK cycle of last row), evaluated in order:
  1. swap_req=1: display_buf toggles, swap_ack=1 for the next cycle (same cycle display_buf shows new value).
  2. bright_req=1 -> BRIGHT, s=0; else enable=1 -> SCAN row 0; else IDLE, row/slot reset to 0.
- BRIGHT: one slot-length pass, load_brightness at s=0 (never load_led_vals), oe_n=1, rows off, pwm_time 0. After s=STEP_LEN-1: bright_ack=1 next cycle; -> SCAN row 0 if enable, else IDLE.
- enable deassert mid-frame: frame completes; stop only at boundary. Requests dropped before boundary are ignored; held requests are serviced at the next boundary only.
- Frame length (no BRIGHT): NUM_ROWS*(2**PWM_BITS*STEP_LEN+BLANK_CYCLES) cycles; BRIGHT adds STEP_LEN.
- Counters wrap only as specified; no other transitions exist.

Test Plan:
Params NUM_ROWS=4, PWM_BITS=2, SHIFT_BITS=2, BLANK_CYCLES=4 (STEP_LEN=7, 32 cycles/row, 128/frame):
- Reset, enable=1 -> frame_start every 128 cycles; per slot exactly 1 load_led_vals, 2 shift, 2 serial_clk highs, 1 latch; pwm_time 0,1,2,3 per row.
- Rows: row_select_n 1110,1101,1011,0111 in SCAN; 1111 with oe_n=1 for exactly 4 cycles between rows.
- swap_req=1 mid-frame -> single swap_ack at cycle after boundary, display_buf 0->1; held request not re-acked until next boundary.
- bright_req and swap_req together -> swap_ack, 7-cycle BRIGHT (1 load_brightness, oe_n=1), bright_ack, next frame_start 7 cycles later than nominal.
- enable=0 at row 1 -> frame finishes, IDLE with oe_n=1, rows 1111; re-enable -> frame_start next cycle+1.
- reset_n low mid-slot (s=3, row 2) -> all outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/led_scan_sequencer.sv
// Scan/PWM timing generator for the LED cube panel drivers.
// Produces per-slot load/shift/sclk/latch strobes, PWM slot, row address and
// one-cold row selects, with inter-row blanking, a frame-synchronous buffer
// swap handshake and an on-request brightness load pass.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   enable                        run request (sampled in IDLE / frame boundary)
//   swap_req, bright_req          level requests held until acknowledged
//   serial_clk, shift             driver shift clock / shift strobe
//   load_led_vals, load_brightness driver capture strobes
//   latch_enable, output_enable_n driver latch strobe / active-low output enable
//   pwm_time, active_row_addr     current PWM slot / current row
//   row_select_n                  one-cold row drive
//   display_buf                   currently displayed buffer
//   frame_start                   first cycle of each frame
//   swap_ack, bright_ack          one-cycle acknowledges
module led_scan_sequencer #(
    parameter int unsigned NUM_ROWS     = 16,
    parameter int unsigned ROW_ADDR_W   = 4,
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned SHIFT_BITS   = 32,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  swap_req,
    input  logic                  bright_req,
    output logic                  serial_clk,
    output logic                  shift,
    output logic                  load_led_vals,
    output logic                  load_brightness,
    output logic                  latch_enable,
    output logic                  output_enable_n,
    output logic [PWM_BITS-1:0]   pwm_time,
    output logic [ROW_ADDR_W-1:0] active_row_addr,
    output logic [NUM_ROWS-1:0]   row_select_n,
    output logic                  display_buf,
    output logic                  frame_start,
    output logic                  swap_ack,
    output logic                  bright_ack
);

    localparam int unsigned STEP_LEN = 2 * SHIFT_BITS + 3;
    localparam int unsigned STEP_W   = $clog2(STEP_LEN);
    localparam int unsigned BLANK_W  = $clog2(BLANK_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_BLANK  = 2'd2;
    localparam logic [1:0] S_BRIGHT = 2'd3;

    logic [1:0]            r_state, w_state_nxt;
    logic [STEP_W-1:0]     r_step, w_step_nxt;
    logic [PWM_BITS-1:0]   r_slot, w_slot_nxt;
    logic [ROW_ADDR_W-1:0] r_row, w_row_nxt;
    logic [BLANK_W-1:0]    r_blank, w_blank_nxt;
    logic                  r_buf, w_buf_nxt;
    logic                  w_swap_ack_nxt, w_bright_ack_nxt;

    // Output decode of the next state; registered so outputs track state exactly.
    logic                  w_pass, w_load_led, w_load_bri, w_shift, w_sclk, w_latch;
    logic                  w_oe_n, w_frame_start;
    logic [NUM_ROWS-1:0]   w_row_sel_n;
    logic [PWM_BITS-1:0]   w_pwm;

    logic                  r_sclk, r_shift, r_load_led, r_load_bri, r_latch, r_oe_n;
    logic [PWM_BITS-1:0]   r_pwm;
    logic [NUM_ROWS-1:0]   r_row_sel_n;
    logic                  r_frame_start, r_swap_ack, r_bright_ack;

    // Next-state logic
    always_comb begin
        w_state_nxt      = r_state;
        w_step_nxt       = r_step;
        w_slot_nxt       = r_slot;
        w_row_nxt        = r_row;
        w_blank_nxt      = r_blank;
        w_buf_nxt        = r_buf;
        w_swap_ack_nxt   = 1'b0;
        w_bright_ack_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_SCAN;
                    w_step_nxt  = '0;
                    w_slot_nxt  = '0;
                    w_row_nxt   = '0;
                end
            end
            S_SCAN: begin
                if (r_step == STEP_W'(STEP_LEN - 1)) begin
                    w_step_nxt = '0;
                    if (r_slot == '1) begin
                        w_state_nxt = S_BLANK;
                        w_blank_nxt = '0;
                    end else begin
                        w_slot_nxt = r_slot + PWM_BITS'(1);
                    end
                end else begin
                    w_step_nxt = r_step + STEP_W'(1);
                end
            end
            S_BLANK: begin
                if (r_blank == BLANK_W'(BLANK_CYCLES - 1)) begin
                    w_step_nxt = '0;
                    w_slot_nxt = '0;
                    if (r_row != ROW_ADDR_W'(NUM_ROWS - 1)) begin
                        w_row_nxt   = r_row + ROW_ADDR_W'(1);
                        w_state_nxt = S_SCAN;
                    end else begin
                        // Frame boundary: swap first, then brightness, then run/stop.
                        w_row_nxt = '0;
                        if (swap_req) begin
                            w_buf_nxt      = ~r_buf;
                            w_swap_ack_nxt = 1'b1;
                        end
                        if (bright_req)  w_state_nxt = S_BRIGHT;
                        else if (enable) w_state_nxt = S_SCAN;
                        else             w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_blank_nxt = r_blank + BLANK_W'(1);
                end
            end
            S_BRIGHT: begin
                if (r_step == STEP_W'(STEP_LEN - 1)) begin
                    w_step_nxt       = '0;
                    w_bright_ack_nxt = 1'b1;
                    w_state_nxt      = enable ? S_SCAN : S_IDLE;
                end else begin
                    w_step_nxt = r_step + STEP_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Strobe and row decode for the upcoming cycle
    always_comb begin
        w_pass        = (w_state_nxt == S_SCAN) || (w_state_nxt == S_BRIGHT);
        w_load_led    = (w_state_nxt == S_SCAN) && (w_step_nxt == '0);
        w_load_bri    = (w_state_nxt == S_BRIGHT) && (w_step_nxt == '0);
        w_shift       = w_pass && w_step_nxt[0] && (w_step_nxt <= STEP_W'(2 * SHIFT_BITS));
        w_sclk        = w_pass && !w_step_nxt[0] && (w_step_nxt >= STEP_W'(2))
                        && (w_step_nxt <= STEP_W'(2 * SHIFT_BITS));
        w_latch       = w_pass && (w_step_nxt == STEP_W'(2 * SHIFT_BITS + 1));
        w_oe_n        = (w_state_nxt != S_SCAN);
        w_pwm         = (w_state_nxt == S_BRIGHT) ? '0 : w_slot_nxt;
        w_frame_start = (w_state_nxt == S_SCAN) && (w_row_nxt == '0)
                        && (w_slot_nxt == '0) && (w_step_nxt == '0);
        w_row_sel_n   = '1;
        for (int i = 0; i < int'(NUM_ROWS); i++) begin
            w_row_sel_n[i] = !((w_state_nxt == S_SCAN) && (w_row_nxt == ROW_ADDR_W'(i)));
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_step        <= '0;
            r_slot        <= '0;
            r_row         <= '0;
            r_blank       <= '0;
            r_buf         <= 1'b0;
            r_sclk        <= 1'b0;
            r_shift       <= 1'b0;
            r_load_led    <= 1'b0;
            r_load_bri    <= 1'b0;
            r_latch       <= 1'b0;
            r_oe_n        <= 1'b1;
            r_pwm         <= '0;
            r_row_sel_n   <= '1;
            r_frame_start <= 1'b0;
            r_swap_ack    <= 1'b0;
            r_bright_ack  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_step        <= w_step_nxt;
            r_slot        <= w_slot_nxt;
            r_row         <= w_row_nxt;
            r_blank       <= w_blank_nxt;
            r_buf         <= w_buf_nxt;
            r_sclk        <= w_sclk;
            r_shift       <= w_shift;
            r_load_led    <= w_load_led;
            r_load_bri    <= w_load_bri;
            r_latch       <= w_latch;
            r_oe_n        <= w_oe_n;
            r_pwm         <= w_pwm;
            r_row_sel_n   <= w_row_sel_n;
            r_frame_start <= w_frame_start;
            r_swap_ack    <= w_swap_ack_nxt;
            r_bright_ack  <= w_bright_ack_nxt;
        end
    end

    assign serial_clk      = r_sclk;
    assign shift           = r_shift;
    assign load_led_vals   = r_load_led;
    assign load_brightness = r_load_bri;
    assign latch_enable    = r_latch;
    assign output_enable_n = r_oe_n;
    assign pwm_time        = r_pwm;
    assign active_row_addr = r_row;
    assign row_select_n    = r_row_sel_n;
    assign display_buf     = r_buf;
    assign frame_start     = r_frame_start;
    assign swap_ack        = r_swap_ack;
    assign bright_ack      = r_bright_ack;

endmodule
